// File: rtl/venc_hs_crc16_attach_if.sv
// Bit-serial handshake bundle for the CRC16 attachment unit: upstream message
// bits in (din side) and the message-plus-parity stream out (dout side).
interface venc_hs_crc16_attach_if;
  logic din;
  logic din_vld;
  logic din_last;
  logic din_rdy;
  logic dout;
  logic dout_vld;
  logic dout_last;
  logic dout_rdy;

  modport master (
    output din, din_vld, din_last, dout_rdy,
    input  din_rdy, dout, dout_vld, dout_last
  );

  modport slave (
    input  din, din_vld, din_last, dout_rdy,
    output din_rdy, dout, dout_vld, dout_last
  );
endinterface

// File: rtl/venc_hs_crc16_attach.sv
// Serial CRC16 attach (g = D^16 + D^12 + D^5 + 1): echoes message bits, then appends 16 parity bits MSB first.
// Optional UE-ID parity masking is enabled by defining VENC_HS_CRC16_UEID_EN.
module venc_hs_crc16_attach (
  input  logic                       clk,
  input  logic                       rst_n,
  venc_hs_crc16_attach_if.slave      bus,
`ifdef VENC_HS_CRC16_UEID_EN
  input  logic [15:0]                ue_id,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam logic [15:0] POLY = 16'h1021;

  state_t      state;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [15:0] mask;
  logic [3:0]  pcnt;
  logic [3:0]  pidx;
  logic        out_bit;
  logic        out_vld;
  logic        out_last;
  logic        out_free;
  logic        in_xfer;
  logic        fb;
  logic        par_bit;

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free    = !out_vld | bus.dout_rdy;
  assign bus.din_rdy = rst_n & (state != PARITY) & out_free;
  assign in_xfer     = bus.din_vld & bus.din_rdy;

  assign bus.dout      = out_bit;
  assign bus.dout_vld  = out_vld;
  assign bus.dout_last = out_last;
  assign busy          = (state != IDLE);

  assign fb          = crc[15] ^ bus.din;
  assign crc_next[0] = fb;

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_crc
      assign crc_next[gi] = crc[gi-1] ^ (POLY[gi] & fb);
    end
  endgenerate

  // Bit sent at pcnt=k is crc[15-k]; for a 4-bit counter 15-k == ~k.
  assign pidx    = ~pcnt;
  assign par_bit = crc[pidx] ^ mask[pidx];

`ifdef VENC_HS_CRC16_UEID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (in_xfer && bus.din_last) begin
      mask <= ue_id;
    end
  end
`else
  assign mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc      <= '0;
      pcnt     <= '0;
      out_bit  <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DATA: begin
          if (in_xfer) begin
            crc      <= crc_next;
            out_bit  <= bus.din;
            out_vld  <= 1'b1;
            out_last <= 1'b0;
            state    <= bus.din_last ? PARITY : DATA;
          end else if (bus.dout_rdy) begin
            out_vld <= 1'b0;
          end
        end
        PARITY: begin
          // Once the final parity beat is loaded, hold it until it transfers.
          if (out_vld && out_last) begin
            if (bus.dout_rdy) begin
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              crc      <= '0;
              pcnt     <= '0;
              state    <= IDLE;
            end
          end else if (out_free) begin
            out_bit  <= par_bit;
            out_vld  <= 1'b1;
            out_last <= (pcnt == 4'd15);
            pcnt     <= pcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_venc_hs_crc16_attach.sv
// Scoreboard bench for venc_hs_crc16_attach: directed frames with known parity plus
// random frames checked against a polynomial long-division reference model.
module tb_venc_hs_crc16_attach;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] ue_id = 16'h0000;

  always #5 clk = ~clk;

  venc_hs_crc16_attach_if bus();

  venc_hs_crc16_attach dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef VENC_HS_CRC16_UEID_EN
    .ue_id (ue_id),
`endif
    .busy  (busy)
  );

  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];       // {bit, last}
  int         frame_beats = 0;
  bit         rdy_random = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Remainder of msg(x)*x^16 divided by g(x), by explicit long division.
  function automatic logic [15:0] model_crc(input logic [0:127] msg, input int n);
    logic        a[0:143];
    logic [16:0] g = 17'h11021;
    logic [15:0] r;
    for (int i = 0; i < 144; i++) a[i] = (i < n) ? msg[i] : 1'b0;
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ g[16-j];
    for (int k = 0; k < 16; k++) r[15-k] = a[n+k];
    return r;
  endfunction

  task automatic send_frame(input logic [0:127] msg, input int n, input logic [15:0] par);
    int w;
    for (int i = 0; i < n; i++) exp_q.push_back({msg[i], 1'b0});
    for (int k = 0; k < 16; k++) exp_q.push_back({par[15-k], (k == 15) ? 1'b1 : 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (rdy_random && $urandom_range(0, 3) == 0) begin
        bus.din_vld  = 1'b0;
        bus.din_last = 1'($urandom_range(0, 1));
        bus.din      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      bus.din      = msg[i];
      bus.din_vld  = 1'b1;
      bus.din_last = (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!bus.din_rdy && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (w >= 200) begin
        check("din_rdy_timeout", 16'(w), 16'd0);
        break;
      end
      @(posedge clk); #1;
    end
    bus.din_vld  = 1'b0;
    bus.din_last = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", 16'(exp_q.size()), 16'd0);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    bus.dout_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pops, stall stability, din_rdy gating, busy release.
  logic prev_stall = 1'b0, prev_last_xfer = 1'b0;
  logic prev_dout = 1'b0, prev_last = 1'b0;
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld_hold", 16'(bus.dout_vld), 16'd1);
        check("stall_dout_hold", 16'({bus.dout, bus.dout_last}), 16'({prev_dout, prev_last}));
      end
      if (prev_last_xfer) check("busy_after_last", 16'(busy), 16'd0);
      if (bus.dout_vld && !bus.dout_rdy) check("din_rdy_while_stalled", 16'(bus.din_rdy), 16'd0);
      if (bus.dout_vld && bus.dout_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 16'({bus.dout, bus.dout_last}), 16'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d", frame_beats), 16'({bus.dout, bus.dout_last}), 16'(e));
        end
        frame_beats = bus.dout_last ? 0 : frame_beats + 1;
      end
      prev_stall     = bus.dout_vld && !bus.dout_rdy;
      prev_last_xfer = bus.dout_vld && bus.dout_rdy && bus.dout_last;
      prev_dout      = bus.dout;
      prev_last      = bus.dout_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:127] m;
    logic [0:127] ascii;
    logic [15:0]  mk;
    string        s = "123456789";
    byte          c;
    int           n, w;

    bus.din = 1'b0; bus.din_vld = 1'b0; bus.din_last = 1'b0; bus.dout_rdy = 1'b1;
    ascii = '0;
    for (int b = 0; b < 9; b++) begin
      c = s[b];
      for (int k = 0; k < 8; k++) ascii[b*8+k] = c[7-k];
    end

    // Reset values while held, then din_rdy after release
    #22;
    check("rst_dout", 16'(bus.dout), 16'd0);
    check("rst_dout_vld", 16'(bus.dout_vld), 16'd0);
    check("rst_dout_last", 16'(bus.dout_last), 16'd0);
    check("rst_din_rdy", 16'(bus.din_rdy), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_din_rdy", 16'(bus.din_rdy), 16'd1);

    m = '0; m[0] = 1'b1;
    send_frame(m, 1, 16'h1021); wait_drain();
    m = '0;
    send_frame(m, 1, 16'h0000); wait_drain();
    send_frame(ascii, 72, 16'h31C3); wait_drain();
    rdy_random = 1'b1;
    send_frame(ascii, 72, 16'h31C3); wait_drain();

    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 100);
      m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'($urandom_range(0, 1));
      ue_id = 16'($urandom);
`ifdef VENC_HS_CRC16_UEID_EN
      mk = ue_id;
`else
      mk = 16'h0000;
`endif
      send_frame(m, n, model_crc(m, n) ^ mk); wait_drain();
    end
    ue_id = 16'h0000;

    // Reset in the middle of the parity tail
    rdy_random = 1'b0;
    send_frame(ascii, 72, 16'h31C3);
    w = 0;
    while (frame_beats < 80 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("mid_parity_reach", 16'(frame_beats >= 80), 16'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("midrst_dout", 16'(bus.dout), 16'd0);
    check("midrst_dout_vld", 16'(bus.dout_vld), 16'd0);
    check("midrst_dout_last", 16'(bus.dout_last), 16'd0);
    check("midrst_din_rdy", 16'(bus.din_rdy), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    exp_q.delete();
    frame_beats = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    check("midrst_release_din_rdy", 16'(bus.din_rdy), 16'd1);
    m = '0; m[0] = 1'b1;
    send_frame(m, 1, 16'h1021); wait_drain();

`ifdef VENC_HS_CRC16_UEID_EN
    ue_id = 16'hFFFF;
    m = '0;
    send_frame(m, 1, 16'hFFFF); wait_drain();
    ue_id = 16'h1021;
    m = '0; m[0] = 1'b1;
    send_frame(m, 1, 16'h0000); wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
